alu_seq: RTL
============

Name: alu_seq

Overview:
- Registered, handshaked, width-parametrised successor to the combinational ALU; sits between operand fetch and writeback in the lab CPU datapath.
- Keeps the existing opcode map and adds variable shift amounts, unsigned compare and an iterative shift-add multiply.
- Single-cycle ops return after 1 cycle; MUL takes WIDTH cycles.
- Valid/ready on both sides so the core can stall the ALU or be stalled by it.

Parameters:
- WIDTH, 32, operand/result width; power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), derived localparam; shift-amount width taken from operand_1[SHAMT_W-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request this cycle
- opcode  input  4  operation select
- operand_0  input  WIDTH  first operand
- operand_1  input  WIDTH  second operand / shift amount
- out_valid  output  1  result, zero and illegal are valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- illegal  output  1  opcode not in map

Behaviour:
- Interface fact: one clock; reset is asynchronous and active-low.
  - rst_n low forces state IDLE.
  - Outputs cleared: out_valid=0, result=0, zero=0, illegal=0, MUL counter=0.
  - in_ready=0 while rst_n is low; 1 in the first cycle after release.
- Opcodes (names/encodings unchanged from the existing ALU):
  - ADD 0000; SUB 0001; AND 0010; OR 0011; XOR 0100.
  - SHL_LOGICAL 0110; SHR_LOGICAL 0111; SHR_ARITHMETIC 1000.
  - LESS_THAN 1001 (signed); LESS_THAN_U 1010 (unsigned); MUL 1011 (low WIDTH bits of product).
  - Any other code: result=0, illegal=1, single-cycle latency.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry out.
  - Shift amount = operand_1[SHAMT_W-1:0]; upper bits ignored.
  - SHR_ARITHMETIC replicates operand_0[WIDTH-1].
  - Compares return {WIDTH-1 zeros, bit}.
  - MUL is sign-agnostic (low half is identical for signed and unsigned).
- Handshake:
  - Request accepted on a rising edge with in_valid && in_ready.
  - Operands and opcode are captured at accept; the inputs may then change freely.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Result is consumed on an edge with out_valid && out_ready.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - Accept of a non-MUL op -> DONE, result registered at that edge.
    - Accept of MUL -> MUL_BUSY, count=0, acc=0, multiplicand=operand_0, multiplier=operand_1.
  - MUL_BUSY: in_ready=0, out_valid=0.
    - Each edge: if multiplier[0], acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++.
    - At the edge where count reaches WIDTH-1 (the WIDTH-th busy edge) -> DONE with result=acc.
  - DONE: out_valid=1; result/zero/illegal held stable while out_ready=0.
    - out_ready=1 and no new accept -> IDLE.
    - out_ready=1 and in_valid=1 -> simultaneous consume and accept; next state as for accept from IDLE.
- Latency (accept at edge k):
  - Non-MUL: out_valid high after edge k+1? No: after edge k. Back-to-back throughput is 1 op/cycle when out_ready is held high.
  - MUL: out_valid high after edge k+WIDTH.
- zero and illegal are registered together with result and change only on a DONE entry.
- Reset mid-operation (MUL_BUSY or DONE): operation and result are discarded; no out_valid after reset release.
- in_valid while in_ready=0 is ignored; no request is queued.

Test Plan:
- ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> out_valid the cycle after accept, result=0x00000000, zero=1, illegal=0.
- SHR_ARITHMETIC operand_0=0x80000000, operand_1=0x00000024 -> result=0xF8000000 (shamt 4, upper bits ignored); SHL_LOGICAL 0x00000001 by 31 -> 0x80000000.
- LESS_THAN 0xFFFFFFFF vs 0x00000001 -> 0x00000001; LESS_THAN_U on the same operands -> 0x00000000; opcode 0101 -> result=0, illegal=1.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> result=0x00000001 exactly 32 cycles after accept, in_ready=0 throughout; MUL 0x00010000*0x00010000 -> 0x00000000, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after SUB 5-7 -> result stays 0xFFFFFFFE with out_valid=1, in_ready=0; then assert out_ready with in_valid (XOR 0xF0F0F0F0^0xFFFFFFFF) -> next cycle result=0x0F0F0F0F.
- Reset mid-MUL: drop rst_n 10 cycles after MUL accept -> out_valid=0 and result=0 immediately (asynchronous); after release no stale result appears and in_ready=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with variable shifts, signed/unsigned compare and
// an iterative shift-add multiplier. Single-cycle ops complete at the accept
// edge; MUL completes WIDTH edges after accept.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] operand_0,
  input  logic [WIDTH-1:0] operand_1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SHL   = 4'b0110;
  localparam logic [3:0] OP_SHR   = 4'b0111;
  localparam logic [3:0] OP_SRA   = 4'b1000;
  localparam logic [3:0] OP_LT    = 4'b1001;
  localparam logic [3:0] OP_LTU   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic                 out_valid_d;
  logic [WIDTH-1:0]     result_d;
  logic                 zero_d;
  logic                 illegal_d;

  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_ill;
  logic                 lt_s;
  logic                 lt_u;
  logic [WIDTH-1:0]     acc_sum;
  logic                 accept;

  // Ready while idle, or while finishing when the consumer takes the result.
  assign in_ready = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // Single-cycle result from the live request inputs.
  always_comb begin
    shamt   = operand_1[SHAMT_W-1:0];
    lt_s    = $signed(operand_0) < $signed(operand_1);
    lt_u    = operand_0 < operand_1;
    alu_res = '0;
    alu_ill = 1'b0;
    case (opcode)
      OP_ADD:  alu_res = operand_0 + operand_1;
      OP_SUB:  alu_res = operand_0 - operand_1;
      OP_AND:  alu_res = operand_0 & operand_1;
      OP_OR:   alu_res = operand_0 | operand_1;
      OP_XOR:  alu_res = operand_0 ^ operand_1;
      OP_SHL:  alu_res = operand_0 << shamt;
      OP_SHR:  alu_res = operand_0 >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(operand_0) >>> shamt);
      OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_LTU:  alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_MUL:  alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One shift-add step of the multiplier.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    out_valid_d = out_valid;
    result_d    = result;
    zero_d      = zero;
    illegal_d   = illegal;
    case (state_q)
      IDLE, DONE: begin
        if ((state_q == DONE) && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (opcode == OP_MUL) begin
            state_d     = MUL_BUSY;
            out_valid_d = 1'b0;
            count_d     = '0;
            acc_d       = '0;
            mcand_d     = operand_0;
            mplier_d    = operand_1;
          end else begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            illegal_d   = alu_ill;
          end
        end
      end
      MUL_BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + SHAMT_W'(1);
        if (count_q == SHAMT_W'(WIDTH - 1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = acc_sum;
          zero_d      = (acc_sum == '0);
          illegal_d   = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State, multiplier datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      count_q   <= '0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      zero      <= zero_d;
      illegal   <= illegal_d;
    end
  end

endmodule
